// File: rtl/table_mp_pkg.sv
// Shared types and lane-slicing helpers for the multi-ported lookup table.
package table_mp_pkg;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Lane k of a packed bus occupies [lane_lo(k,w) +: w], i.e. [(k+1)*w-1 -: w].
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/table_mp_rd_port.sv
// One read-port pipeline: registers a lookup result and presents it RD_LATENCY cycles later.
module table_mp_rd_port
  import table_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LAT_MIN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  hit,
  output logic                  valid
);

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  hit_p0;

  // p0: capture the lookup; data and hit hold until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      hit_p0  <= 1'b0;
    end else begin
      vld_p0 <= en;
      if (en) begin
        data_p0 <= lookup_data;
        hit_p0  <= lookup_hit;
      end
    end
  end

  generate
    if (RD_LATENCY == RD_LAT_MAX) begin : g_lat2
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] data_p1;
      logic                  hit_p1;

      // p1: second stage, again holding between completed reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          hit_p1  <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            data_p1 <= data_p0;
            hit_p1  <= hit_p0;
          end
        end
      end

      assign data  = data_p1;
      assign hit   = hit_p1;
      assign valid = vld_p1;
    end else begin : g_lat1
      assign data  = data_p0;
      assign hit   = hit_p0;
      assign valid = vld_p0;
    end
  endgenerate

endmodule

// File: rtl/table_mp.sv
// Multi-ported table with per-entry valid bits, a sweeping clear FSM and pipelined reads.
// Define TABLE_MP_BYPASS_EN to forward same-cycle write data to colliding reads.
module table_mp
  import table_mp_pkg::*;
#(
  parameter  int TABLE_SIZE = 32,
  parameter  int DATA_WIDTH = 8,
  parameter  int WR_PORTS   = 2,
  parameter  int RD_PORTS   = 2,
  parameter  int RD_LATENCY = 1,
  localparam int IW         = $clog2(TABLE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*IW-1:0]         wr_idx,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*IW-1:0]         rd_idx,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [RD_PORTS-1:0]            rd_hit,
  input  logic                           clr_req,
  output logic                           clr_busy
);

  logic [DATA_WIDTH-1:0] mem [TABLE_SIZE];
  logic [TABLE_SIZE-1:0] vbit;
  clr_state_t            state;
  logic [IW-1:0]         ptr;

  logic [DATA_WIDTH-1:0] look_data [RD_PORTS];
  logic [RD_PORTS-1:0]   look_hit;

  function automatic logic in_range(input logic [IW-1:0] i);
    return int'(i) < TABLE_SIZE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLR_IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clr_req) begin
            state    <= CLR_SWEEP;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (ptr == IW'(TABLE_SIZE - 1)) begin
            state    <= CLR_IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state    <= CLR_IDLE;
          ptr      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Sweep clear first, then writes in ascending port order: writes beat the clear
  // and the highest-numbered port wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_SIZE; i++) mem[i] <= '0;
      vbit <= '0;
    end else begin
      if (state == CLR_SWEEP) begin
        mem[ptr]  <= '0;
        vbit[ptr] <= 1'b0;
      end
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && in_range(wr_idx[lane_lo(p, IW) +: IW])) begin
          mem[wr_idx[lane_lo(p, IW) +: IW]]  <= wr_data[lane_lo(p, DATA_WIDTH) +: DATA_WIDTH];
          vbit[wr_idx[lane_lo(p, IW) +: IW]] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) begin
      look_data[r] = '0;
      look_hit[r]  = 1'b0;
      if (in_range(rd_idx[lane_lo(r, IW) +: IW]) && vbit[rd_idx[lane_lo(r, IW) +: IW]]) begin
        look_data[r] = mem[rd_idx[lane_lo(r, IW) +: IW]];
        look_hit[r]  = 1'b1;
      end
`ifdef TABLE_MP_BYPASS_EN
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_en[p] && in_range(rd_idx[lane_lo(r, IW) +: IW]) &&
            (wr_idx[lane_lo(p, IW) +: IW] == rd_idx[lane_lo(r, IW) +: IW])) begin
          look_data[r] = wr_data[lane_lo(p, DATA_WIDTH) +: DATA_WIDTH];
          look_hit[r]  = 1'b1;
        end
      end
`endif
    end
  end

  generate
    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
      table_mp_rd_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LATENCY(RD_LATENCY)
      ) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (rd_en[r]),
        .lookup_data(look_data[r]),
        .lookup_hit (look_hit[r]),
        .data       (rd_data[lane_lo(r, DATA_WIDTH) +: DATA_WIDTH]),
        .hit        (rd_hit[r]),
        .valid      (rd_valid[r])
      );
    end
  endgenerate

endmodule
